catc_stall_scheduler: RTL

//  Shares one long-latency memory/service port among N requesters and drives the CATC timing

---
 rtl/catc_pkg.sv | 24 ++
 rtl/catc_rr_arbiter.sv | 32 +++
 rtl/catc_stall_scheduler.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/catc_pkg.sv
// Shared types and defaults for the CATC stall scheduler.
// The optional STALL_STATS_EN build adds statistics counters to the top module.
package catc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } catcState_e;

    localparam int DefNumReq        = 4;
    localparam int DefFastThreshold = 64;
    localparam int DefBacklogBits   = 16;
    localparam int DefTimeout       = 4096;

    // (a + b) mod n for operands already below n
    function automatic int wrapAdd(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/catc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module catc_rr_arbiter
    import catc_pkg::*;
#(
    parameter int NumReq  = DefNumReq,
    parameter int IdxBits = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]  Req,
    input  logic [IdxBits-1:0] Ptr,
    output logic               Valid,
    output logic [NumReq-1:0]  OneHot,
    output logic [IdxBits-1:0] Idx
);

    logic [IdxBits-1:0] candIdx;

    always_comb begin
        Valid   = 1'b0;
        OneHot  = '0;
        Idx     = '0;
        candIdx = '0;
        for (int off = 0; off < NumReq; off++) begin
            candIdx = IdxBits'(wrapAdd(int'(Ptr), off, NumReq));
            if (!Valid && Req[candIdx]) begin
                Valid           = 1'b1;
                Idx             = candIdx;
                OneHot[candIdx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/catc_stall_scheduler.sv
// Shares one long-latency service port among NumReq requesters and drives CATC Delay/FastCatchup.
// Define STALL_STATS_EN to add the StallCycles, GrantCount and TimeoutCount outputs.
//
//  state | meaning
//  IDLE  | no transaction; arbitrate among Req
//  GRANT | winner latched, MemReq pulsed
//  WAIT  | waiting for MemDone or timeout
//  DONE  | Done (and Abort on timeout) pulsed to the winner
module catc_stall_scheduler
    import catc_pkg::*;
#(
    parameter int NumReq        = DefNumReq,
    parameter int FastThreshold = DefFastThreshold,
    parameter int BacklogBits   = DefBacklogBits,
    parameter int Timeout       = DefTimeout
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ClkEn,
    input  logic [NumReq-1:0] Req,
    input  logic [NumReq-1:0] Blocking,
    output logic [NumReq-1:0] Gnt,
    output logic [NumReq-1:0] Done,
    output logic              Abort,
    output logic              MemReq,
    input  logic              MemDone,
    output logic              Delay,
    output logic              FastCatchup,
    output logic              Busy
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]             StallCycles,
    output logic [NumReq-1:0][15:0] GrantCount,
    output logic [7:0]              TimeoutCount
`endif
);

    localparam int IdxBits = $clog2(NumReq);
    localparam int TmoBits = $clog2(Timeout + 1);
    localparam logic [BacklogBits-1:0] FastThr = BacklogBits'(FastThreshold);

    catcState_e         state, stateNext;
    logic [NumReq-1:0]  gntQ, gntNext;
    logic               blkQ, blkNext;
    logic [IdxBits-1:0] ptrQ, ptrNext;
    logic [TmoBits-1:0] tmoQ, tmoNext;
    logic               abortQ, abortNext;
    logic               delayQ;
    logic [BacklogBits-1:0] backlog, backlogNext;
    logic               fcQ, fcNext;

    logic               arbValid;
    logic [NumReq-1:0]  arbOneHot;
    logic [IdxBits-1:0] arbIdx;

    catc_rr_arbiter #(.NumReq(NumReq), .IdxBits(IdxBits)) uArb (
        .Req    (Req),
        .Ptr    (ptrQ),
        .Valid  (arbValid),
        .OneHot (arbOneHot),
        .Idx    (arbIdx)
    );

    always_comb begin
        stateNext = state;
        gntNext   = gntQ;
        blkNext   = blkQ;
        ptrNext   = ptrQ;
        tmoNext   = tmoQ;
        abortNext = abortQ;
        case (state)
            IDLE: begin
                if (arbValid) begin
                    stateNext = GRANT;
                    gntNext   = arbOneHot;
                    blkNext   = Blocking[arbIdx];
                    ptrNext   = IdxBits'(wrapAdd(int'(arbIdx), 1, NumReq));
                    abortNext = 1'b0;
                end
            end
            GRANT: begin
                stateNext = WAIT;
                tmoNext   = TmoBits'(Timeout - 1);
            end
            WAIT: begin
                // a completion on the last permitted cycle wins over the timeout
                if (MemDone) begin
                    stateNext = DONE;
                end else if (tmoQ == '0) begin
                    stateNext = DONE;
                    abortNext = 1'b1;
                end else begin
                    tmoNext = tmoQ - 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            gntQ   <= '0;
            blkQ   <= 1'b0;
            ptrQ   <= '0;
            tmoQ   <= '0;
            abortQ <= 1'b0;
            delayQ <= 1'b0;
        end else begin
            state  <= stateNext;
            gntQ   <= gntNext;
            blkQ   <= blkNext;
            ptrQ   <= ptrNext;
            tmoQ   <= tmoNext;
            abortQ <= abortNext;
            // registered from next-state so Delay never glitches into CATC
            delayQ <= blkNext && ((stateNext == GRANT) || (stateNext == WAIT));
        end
    end

    assign Gnt    = (state != IDLE) ? gntQ : '0;
    assign Done   = (state == DONE) ? gntQ : '0;
    assign Abort  = (state == DONE) && abortQ;
    assign MemReq = (state == GRANT);
    assign Busy   = (state != IDLE);
    assign Delay  = delayQ;

    always_comb begin
        backlogNext = backlog;
        if (ClkEn) begin
            if (delayQ) begin
                if (backlog != '1) backlogNext = backlog + 1'b1;
            end else if (fcQ && (backlog != '0)) begin
                backlogNext = backlog - 1'b1;
            end
        end
        fcNext = fcQ;
        if (backlogNext >= FastThr) fcNext = 1'b1;
        else if (backlogNext == '0) fcNext = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            backlog <= '0;
            fcQ     <= 1'b0;
        end else begin
            backlog <= backlogNext;
            fcQ     <= fcNext;
        end
    end

    assign FastCatchup = fcQ;

`ifdef STALL_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCycles  <= '0;
            GrantCount   <= '0;
            TimeoutCount <= '0;
        end else begin
            if (ClkEn && delayQ) StallCycles <= StallCycles + 1'b1;
            if ((state == IDLE) && arbValid) GrantCount[arbIdx] <= GrantCount[arbIdx] + 1'b1;
            if (Abort && (TimeoutCount != 8'hFF)) TimeoutCount <= TimeoutCount + 1'b1;
        end
    end
`endif

endmodule
